// File: rtl/tick_timer.sv
// Countdown minutes:seconds timer driven by the divider's slow square wave.
// Synchronises the wave, detects its rising edges and runs an IDLE/RUN/PAUSE/DONE state machine.
module tick_timer #(
    parameter int unsigned MAX_MIN = 99,
    parameter int unsigned MIN_W   = 7
) (
    input  logic             in,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic             running,
    output logic             done,
    output logic             tick_pulse
);

    localparam int unsigned SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [MIN_W-1:0]   min_n;
    logic [SEC_W-1:0]   sec_n;
    logic               s0;
    logic               s1;
    logic               s2;
    logic               tick_edge;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= tick_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign tick_edge = s1 & ~s2;

    // Next-state and next-count; priority clear > load > stop > start > tick
    always_comb begin
        state_n = state;
        min_n   = minutes;
        sec_n   = seconds;
        if (clear) begin
            state_n = IDLE;
            min_n   = '0;
            sec_n   = '0;
        end else if (load && (state != RUN)) begin
            state_n = IDLE;
            min_n   = (load_min > MIN_MAX) ? MIN_MAX : load_min;
            sec_n   = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = ((minutes == '0) && (seconds == '0)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_n = PAUSE;
                    end else if (tick_edge) begin
                        if (seconds != '0) begin
                            sec_n = seconds - SEC_W'(1);
                        end else if (minutes != '0) begin
                            min_n = minutes - MIN_W'(1);
                            sec_n = SEC_MAX;
                        end
                        if ((min_n == '0) && (sec_n == '0)) begin
                            state_n = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, count and status flags all registered from the next-state values
    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            minutes    <= '0;
            seconds    <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            minutes    <= min_n;
            seconds    <= sec_n;
            running    <= (state_n == RUN);
            done       <= (state_n == DONE);
            tick_pulse <= tick_edge;
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios then random commands/ticks,
// checked against a total-seconds reference model.
module tb_tick_timer;

    localparam int unsigned MIN_W = 7;

    logic             clk;
    logic             rst_n;
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [MIN_W-1:0] load_min;
    logic [5:0]       load_sec;
    logic [MIN_W-1:0] minutes;
    logic [5:0]       seconds;
    logic             running;
    logic             done;
    logic             tick_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: remaining time in seconds, mode 0=idle 1=run 2=pause 3=done
    int       m_rem;
    int       m_mode;
    logic [2:0] m_hist;
    logic     e_tick;

    tick_timer #(.MAX_MIN(99), .MIN_W(MIN_W)) dut (
        .in        (clk),
        .reset     (rst_n),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .minutes   (minutes),
        .seconds   (seconds),
        .running   (running),
        .done      (done),
        .tick_pulse(tick_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_mode = 0;
        m_hist = 3'b000;
        e_tick = 1'b0;
    endtask

    // One clock edge of the reference model; m_hist[i] is tick_in sampled i+1 edges ago
    task automatic model_step();
        logic ev;
        ev = m_hist[1] & ~m_hist[2];
        if (clear) begin
            m_rem  = 0;
            m_mode = 0;
        end else if (load && m_mode != 1) begin
            m_rem  = clamp(int'(load_min), 99) * 60 + clamp(int'(load_sec), 59);
            m_mode = 0;
        end else if (stop && m_mode == 1) begin
            m_mode = 2;
        end else if (start && m_mode == 2) begin
            m_mode = 1;
        end else if (start && m_mode == 0) begin
            m_mode = (m_rem == 0) ? 3 : 1;
        end else if (ev && m_mode == 1) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mode = 3;
        end
        e_tick = ev;
        m_hist = {m_hist[1:0], tick_in};
    endtask

    task automatic check_model();
        chk("minutes",    32'(minutes),    32'(m_rem / 60));
        chk("seconds",    32'(seconds),    32'(m_rem % 60));
        chk("running",    32'(running),    32'(m_mode == 1));
        chk("done",       32'(done),       32'(m_mode == 3));
        chk("tick_pulse", 32'(tick_pulse), 32'(e_tick));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (tick_pulse === 1'b1) pulses++;
        check_model();
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        repeat (3) cycle();
        tick_in = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic do_load(input int mn, input int sc);
        load     = 1'b1;
        load_min = MIN_W'(mn);
        load_sec = 6'(sc);
        cycle();
        load     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        int hold;
        rst_n    = 1'b0;
        tick_in  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_min = '0;
        load_sec = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;
        cycle();

        // Ticks in IDLE pulse but leave 00:00
        pulses = 0;
        repeat (5) tick_once();
        chk("idle_pulses", 32'(pulses), 32'd5);
        chk("idle_sec", 32'(seconds), 32'd0);

        // 01:02 counts down across the minute boundary
        do_load(1, 2);
        pulse_start();
        tick_once();
        chk("dn1_min", 32'(minutes), 32'd1);
        chk("dn1_sec", 32'(seconds), 32'd1);
        tick_once();
        chk("dn2_sec", 32'(seconds), 32'd0);
        tick_once();
        chk("dn3_min", 32'(minutes), 32'd0);
        chk("dn3_sec", 32'(seconds), 32'd59);
        chk("dn3_run", 32'(running), 32'd1);

        // Expiry into DONE, no underflow afterwards
        do_load(0, 0);
        pulse_clear();
        do_load(0, 2);
        pulse_start();
        tick_once();
        chk("exp1_sec", 32'(seconds), 32'd1);
        tick_once();
        chk("exp2_done", 32'(done), 32'd1);
        chk("exp2_run", 32'(running), 32'd0);
        tick_once();
        chk("exp3_sec", 32'(seconds), 32'd0);
        chk("exp3_done", 32'(done), 32'd1);

        // stop coinciding with a tick edge suppresses the decrement
        pulse_clear();
        do_load(0, 10);
        pulse_start();
        tick_in = 1'b1;
        cycle();
        cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_sec", 32'(seconds), 32'd10);
        chk("stop_run", 32'(running), 32'd0);
        tick_in = 1'b0;
        repeat (3) cycle();
        repeat (3) tick_once();
        chk("pause_sec", 32'(seconds), 32'd10);
        pulse_start();
        tick_once();
        chk("resume_sec", 32'(seconds), 32'd9);

        // Clamping and priority
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        do_load(120, 63);
        chk("clamp_min", 32'(minutes), 32'd99);
        chk("clamp_sec", 32'(seconds), 32'd59);
        pulse_clear();
        pulse_start();
        chk("zero_start_done", 32'(done), 32'd1);
        clear = 1'b1;
        do_load(5, 5);
        clear = 1'b0;
        chk("clr_ld_min", 32'(minutes), 32'd0);
        chk("clr_ld_sec", 32'(seconds), 32'd0);
        chk("clr_ld_done", 32'(done), 32'd0);

        // Tick latency: pulse after edge k+2, decrement at edge k+2
        do_load(0, 40);
        pulse_start();
        tick_in = 1'b1;
        cycle();
        chk("lat_k_pulse", 32'(tick_pulse), 32'd0);
        cycle();
        chk("lat_k1_pulse", 32'(tick_pulse), 32'd0);
        chk("lat_k1_sec", 32'(seconds), 32'd40);
        cycle();
        chk("lat_k2_pulse", 32'(tick_pulse), 32'd1);
        chk("lat_k2_sec", 32'(seconds), 32'd39);
        tick_in = 1'b0;
        cycle();
        chk("lat_k3_pulse", 32'(tick_pulse), 32'd0);
        repeat (2) cycle();

        // Asynchronous reset mid-run
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        do_load(0, 30);
        pulse_start();
        chk("ar_run", 32'(running), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        check_model();
        rst_n = 1'b1;
        cycle();

        // Random commands and tick wave
        hold = 1;
        for (int i = 0; i < 600; i++) begin
            hold--;
            if (hold <= 0) begin
                tick_in = ~tick_in;
                hold    = int'($urandom_range(1, 4));
            end
            clear    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 11) == 0);
            stop     = ($urandom_range(0, 14) == 0);
            start    = ($urandom_range(0, 4) == 0);
            load_min = MIN_W'($urandom_range(0, 127));
            load_sec = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) load_min = MIN_W'($urandom_range(0, 1));
            cycle();
        end
        clear = 1'b0;
        load  = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
